// File: rtl/gf16_exp_if.sv
`default_nettype none
// ============================================================================
// Module   : gf16_exp_if
// Brief    : Start/ready/done handshake bundle for the GF(2^4) exponentiator.
//            The master requests A^E. The slave (controller) returns Z.
// Revision : 1.0 - initial release
// ============================================================================
interface gf16_exp_if;
    logic       start;
    logic [3:0] a;
    logic [3:0] e;
    logic       ready;
    logic       busy;
    logic       done;
    logic [3:0] z;

    modport master (
        output start, a, e,
        input  ready, busy, done, z
    );

    modport slave (
        input  start, a, e,
        output ready, busy, done, z
    );
endinterface
`default_nettype wire

// File: rtl/gf16_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : gf16_exp_ctrl
// Brief    : Computes Z = A^E in GF(2^4), with P(x) = x^4 + x^3 + 1.
//            It uses left-to-right square-and-multiply over one shared
//            squarer and one shared multiplier. Latency is 4 + popcount(E).
// Revision : 1.0 - initial release
// ============================================================================
module gf16_exp_ctrl (
    input  wire logic  clk,
    input  wire logic  rst,
    gf16_exp_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SQR  = 2'd1;
    localparam logic [1:0] S_MUL  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0] state_q, state_d;
    logic [3:0] a_q, a_d;
    logic [3:0] e_q, e_d;
    logic [3:0] acc_q, acc_d;
    logic [1:0] idx_q, idx_d;
    logic [3:0] z_q, z_d;
    logic [3:0] sq_w;
    logic [3:0] mul_w;

    // Squaring is linear over GF(2). Only the x^6 (=1111) and x^4 (=1001)
    // terms need reduction.
    function automatic logic [3:0] gf_sq(input logic [3:0] x);
        return {x[3] ^ x[2], x[3] ^ x[1], x[3], x[3] ^ x[2] ^ x[0]};
    endfunction

    // Shift-and-add multiply. The running multiplicand is reduced on every
    // shift (x^4 -> x^3 + 1), so the result never exceeds 4 bits.
    function automatic logic [3:0] gf_mul(input logic [3:0] x, input logic [3:0] y);
        logic [3:0] p;
        logic [3:0] t;
        p = 4'h0;
        t = x;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) begin
                p = p ^ t;
            end
            t = {t[2:0], 1'b0} ^ (t[3] ? 4'h9 : 4'h0);
        end
        return p;
    endfunction

    assign sq_w  = gf_sq(acc_q);
    assign mul_w = gf_mul(acc_q, a_q);

    // Next-state and datapath selection. Each state uses only one of the
    // squarer or the multiplier, so the two are never chained in one cycle.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        e_d     = e_q;
        acc_d   = acc_q;
        idx_d   = idx_q;
        z_d     = z_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    a_d     = bus.a;
                    e_d     = bus.e;
                    acc_d   = 4'h1;
                    idx_d   = 2'd3;
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                acc_d = sq_w;
                if (e_q[idx_q]) begin
                    state_d = S_MUL;
                end else if (idx_q == 2'd0) begin
                    state_d = S_DONE;
                    z_d     = sq_w;
                end else begin
                    idx_d   = idx_q - 2'd1;
                end
            end
            S_MUL: begin
                acc_d = mul_w;
                if (idx_q == 2'd0) begin
                    state_d = S_DONE;
                    z_d     = mul_w;
                end else begin
                    idx_d   = idx_q - 2'd1;
                    state_d = S_SQR;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and operand registers. Reset aborts any operation in progress.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= 4'h0;
            e_q     <= 4'h0;
            acc_q   <= 4'h0;
            idx_q   <= 2'd0;
            z_q     <= 4'h0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            e_q     <= e_d;
            acc_q   <= acc_d;
            idx_q   <= idx_d;
            z_q     <= z_d;
        end
    end

    // The handshake outputs are Moore decodes of the state register.
    assign bus.ready = (state_q == S_IDLE);
    assign bus.busy  = (state_q == S_SQR) || (state_q == S_MUL);
    assign bus.done  = (state_q == S_DONE);
    assign bus.z     = z_q;

endmodule
`default_nettype wire

// File: tb/tb_gf16_exp_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_gf16_exp_ctrl
// Brief    : Directed and exhaustive self-checking bench for gf16_exp_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gf16_exp_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   dones  = 0;
    int   ops    = 0;

    always #5 clk = ~clk;

    gf16_exp_if bus();

    gf16_exp_ctrl dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Count every done cycle seen on the bus.
    always @(negedge clk) begin
        if (bus.done === 1'b1) dones++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference multiply: full polynomial product, then reduce from the top.
    function automatic logic [3:0] m_mul(input logic [3:0] x, input logic [3:0] y);
        logic [7:0] p;
        p = 8'h00;
        for (int i = 0; i < 4; i++) begin
            if (y[i]) p = p ^ ({4'h0, x} << i);
        end
        for (int i = 6; i >= 4; i--) begin
            if (p[i]) p = p ^ (8'h19 << (i - 4));
        end
        return p[3:0];
    endfunction

    function automatic logic [3:0] m_pow(input logic [3:0] x, input logic [3:0] ex);
        logic [3:0] r;
        r = 4'h1;
        for (int i = 0; i < int'(ex); i++) r = m_mul(r, x);
        return r;
    endfunction

    // Issue one request from IDLE and check the result, latency and handshake.
    // Call it #1 after a rising edge, with the controller in IDLE.
    task automatic run_op(input string tag, input logic [3:0] av, input logic [3:0] ev,
                          input logic [3:0] zexp, input int lat);
        int k;
        int busy_n;
        int rdy_lo;
        bit seen;
        chk({tag, ".ready_before"}, bus.ready, 1);
        bus.start = 1'b1;
        bus.a     = av;
        bus.e     = ev;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.a     = 4'($urandom_range(15));
        bus.e     = 4'($urandom_range(15));
        ops++;
        k = 0; busy_n = 0; rdy_lo = 0; seen = 0;
        while (k <= 20) begin
            if (bus.busy === 1'b1) busy_n++;
            if (bus.ready === 1'b0) rdy_lo++;
            if (bus.done === 1'b1) begin
                seen = 1;
                break;
            end
            @(posedge clk); #1;
            k++;
        end
        chk({tag, ".done_seen"}, seen, 1);
        chk({tag, ".latency"}, k, lat);
        chk({tag, ".z"}, bus.z, zexp);
        chk({tag, ".busy_cycles"}, busy_n, lat);
        chk({tag, ".ready_low_cycles"}, rdy_lo, lat + 1);
        @(posedge clk); #1;
        chk({tag, ".done_pulse"}, bus.done, 0);
        chk({tag, ".ready_after"}, bus.ready, 1);
        chk({tag, ".z_hold"}, bus.z, zexp);
    endtask

    initial begin
        int extra;
        bus.start = 1'b0;
        bus.a     = 4'h0;
        bus.e     = 4'h0;

        // Reset state
        #12;
        chk("reset.ready", bus.ready, 1);
        chk("reset.busy",  bus.busy,  0);
        chk("reset.done",  bus.done,  0);
        chk("reset.z",     bus.z,     4'h0);
        @(posedge clk); #3;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle.ready", bus.ready, 1);

        // Directed vectors
        run_op("inv_x",  4'h2, 4'hE, 4'hC, 7);
        run_op("x_pow4", 4'h2, 4'h4, 4'h9, 5);
        run_op("b_pow3", 4'hB, 4'h3, 4'h1, 6);
        run_op("zero0",  4'h0, 4'h0, 4'h1, 4);
        run_op("zero5",  4'h0, 4'h5, 4'h0, 6);
        run_op("zeroE",  4'h0, 4'hE, 4'h0, 7);
        run_op("three_F", 4'h3, 4'hF, 4'h1, 8);

        // Start requests while the controller is busy or in DONE are dropped.
        bus.start = 1'b1; bus.a = 4'h2; bus.e = 4'hE;
        @(posedge clk); #1;                        // edge 0
        bus.start = 1'b0;
        ops++;
        @(posedge clk); #1;                        // edge 1
        @(posedge clk); #1;                        // edge 2
        bus.start = 1'b1; bus.a = 4'h5; bus.e = 4'h1;
        @(posedge clk); #1;                        // edge 3
        bus.start = 1'b0;
        chk("drop.busy_mid", bus.busy, 1);
        repeat (4) begin @(posedge clk); #1; end   // edge 7
        chk("drop.done7", bus.done, 1);
        chk("drop.z7", bus.z, 4'hC);
        bus.start = 1'b1;
        @(posedge clk); #1;                        // edge 8
        bus.start = 1'b0;
        chk("drop.done8", bus.done, 0);
        chk("drop.ready8", bus.ready, 1);
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        chk("drop.no_extra", extra, 0);
        run_op("after_drop", 4'h5, 4'h1, 4'h5, 5);

        // Asynchronous reset in the middle of an operation
        bus.start = 1'b1; bus.a = 4'h2; bus.e = 4'hF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        chk("abort.busy_before", bus.busy, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("abort.z",     bus.z,     4'h0);
        chk("abort.done",  bus.done,  0);
        chk("abort.busy",  bus.busy,  0);
        chk("abort.ready", bus.ready, 1);
        @(posedge clk); #3;
        rst = 1'b0;
        extra = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (bus.done === 1'b1) extra++;
        end
        chk("abort.no_done", extra, 0);
        run_op("fresh", 4'h2, 4'h7, 4'h7, 7);

        // Exhaustive sweep against the reference model
        for (int ai = 0; ai < 16; ai++) begin
            for (int ei = 0; ei < 16; ei++) begin
                run_op($sformatf("ex_a%0h_e%0h", ai, ei), 4'(ai), 4'(ei),
                       m_pow(4'(ai), 4'(ei)), 4 + $countones(4'(ei)));
            end
        end

        #20;
        chk("done_count", dones, ops);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
